// File: rtl/hall_sensor_emulator_pkg.sv
// Hall code definitions shared by the emulator and the commutation decoder,
// so the six-step sequence and the fault/no-connection codes live in one place.
package hall_sensor_emulator_pkg;

   typedef enum logic [2:0] {
      STATE_FAULT   = 3'b000,
      STATE6        = 3'b001,
      STATE4        = 3'b010,
      STATE5        = 3'b011,
      STATE2        = 3'b100,
      STATE1        = 3'b101,
      STATE3        = 3'b110,
      STATE_NO_CONN = 3'b111
   } hall_code_t;

   typedef enum logic [2:0] {
      PHASE_A = 3'b001,
      PHASE_B = 3'b010,
      PHASE_C = 3'b100
   } phase_t;

   typedef logic [2:0] hall_idx_t;

   localparam hall_idx_t IDX_FIRST = 3'd0;
   localparam hall_idx_t IDX_LAST  = 3'd5;

   // Indices 6 and 7 cannot occur; they map to STATE1 so a corrupted idx self-heals.
   function automatic hall_code_t hall_code(input hall_idx_t idx);
      case (idx)
         3'd0:    hall_code = STATE1;
         3'd1:    hall_code = STATE2;
         3'd2:    hall_code = STATE3;
         3'd3:    hall_code = STATE4;
         3'd4:    hall_code = STATE5;
         3'd5:    hall_code = STATE6;
         default: hall_code = STATE1;
      endcase
   endfunction

   function automatic hall_idx_t hall_idx_step(input hall_idx_t idx, input logic ccw);
      if (ccw) hall_idx_step = (idx >= IDX_LAST) ? IDX_FIRST : idx + 3'd1;
      else     hall_idx_step = (idx == IDX_FIRST || idx > IDX_LAST) ? IDX_LAST : idx - 3'd1;
   endfunction

endpackage

// File: rtl/hall_step_timer.sv
// Step period timer: counts clocks while running and ticks when cnt reaches period-1.
// The >= compare makes a shortened period fire on the next cycle instead of wrapping.
module hall_step_timer #(
   parameter int PERIOD_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    run_i,
   input  logic [PERIOD_WIDTH-1:0] period_i,
   output logic                    tick_o
);

   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = '0;
      tick_o = 1'b0;
      if (run_i) begin
         if (cnt_q >= period_i - PERIOD_WIDTH'(1)) tick_o = 1'b1;
         else                                      cnt_d  = cnt_q + PERIOD_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/hall_sensor_emulator.sv
// Hall sensor emulator: six-step code sequencer with signed position count and
// fault/no-connection overrides. All outputs registered; forces never stall the sequencer.
module hall_sensor_emulator
   import hall_sensor_emulator_pkg::*;
#(
   parameter int PERIOD_WIDTH = 16,
   parameter int COUNT_WIDTH  = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          direction,
   input  logic [PERIOD_WIDTH-1:0]       step_period,
   input  logic                          force_fault,
   input  logic                          force_noconn,
   output logic [2:0]                    hall,
   output logic                          step_strobe,
   output logic signed [COUNT_WIDTH-1:0] step_count,
   output logic                          running
);

   logic                          run;
   logic                          tick;
   hall_idx_t                     idx_q, idx_d;
   hall_code_t                    hall_q, hall_d;
   logic signed [COUNT_WIDTH-1:0] count_q, count_d;
   logic                          strobe_q;
   logic                          running_q;

   assign run = enable && (step_period != '0);

   hall_step_timer #(
      .PERIOD_WIDTH (PERIOD_WIDTH)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .run_i    (run),
      .period_i (step_period),
      .tick_o   (tick)
   );

   // hall is loaded from the next idx so it changes on the same edge as step_strobe.
   always_comb begin
      idx_d   = idx_q;
      count_d = count_q;
      if (tick) begin
         idx_d   = hall_idx_step(idx_q, direction);
         count_d = direction ? count_q + COUNT_WIDTH'(1) : count_q - COUNT_WIDTH'(1);
      end
      if (force_fault)       hall_d = STATE_FAULT;
      else if (force_noconn) hall_d = STATE_NO_CONN;
      else                   hall_d = hall_code(idx_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= IDX_FIRST;
         hall_q    <= STATE1;
         count_q   <= '0;
         strobe_q  <= 1'b0;
         running_q <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         hall_q    <= hall_d;
         count_q   <= count_d;
         strobe_q  <= tick;
         running_q <= run;
      end
   end

   assign hall        = hall_q;
   assign step_strobe = strobe_q;
   assign step_count  = count_q;
   assign running     = running_q;

endmodule

// File: tb/tb_hall_sensor_emulator.sv
// Directed bench for hall_sensor_emulator with hand-derived expected sequences.
module tb_hall_sensor_emulator;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               enable = 1'b0;
   logic               direction = 1'b0;
   logic [15:0]        step_period = 16'd0;
   logic               force_fault = 1'b0;
   logic               force_noconn = 1'b0;
   logic [2:0]         hall;
   logic               step_strobe;
   logic signed [15:0] step_count;
   logic               running;

   int tests = 0;
   int fails = 0;
   logic [2:0] tbl [6];

   hall_sensor_emulator #(
      .PERIOD_WIDTH (16),
      .COUNT_WIDTH  (16)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .direction    (direction),
      .step_period  (step_period),
      .force_fault  (force_fault),
      .force_noconn (force_noconn),
      .hall         (hall),
      .step_strobe  (step_strobe),
      .step_count   (step_count),
      .running      (running)
   );

   always #5 clk = ~clk;

   task automatic apply_reset(input logic en, input logic dir, input logic [15:0] per);
      @(posedge clk); #1;
      rst_n        = 1'b0;
      enable       = en;
      direction    = dir;
      step_period  = per;
      force_fault  = 1'b0;
      force_noconn = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset(1'b0, 1'b1, 16'd4);
      tests++;
      if (hall !== 3'b101 || step_strobe !== 1'b0 || step_count !== 16'sd0 || running !== 1'b0) begin
         fails++;
         $display("FAIL reset hall=%b strobe=%b count=%0d running=%b, expected 101 0 0 0",
                  hall, step_strobe, step_count, running);
      end
   endtask

   task automatic test_ccw();
      logic [2:0] eh; logic es; logic signed [15:0] ec;
      apply_reset(1'b1, 1'b1, 16'd4);
      for (int c = 1; c <= 28; c++) begin
         @(posedge clk); #1;
         eh = tbl[(c / 4) % 6]; es = (c % 4 == 0); ec = 16'(c / 4);
         tests++;
         if (hall !== eh || step_strobe !== es || step_count !== ec || running !== 1'b1) begin
            fails++;
            $display("FAIL ccw c=%0d got hall=%b strobe=%b count=%0d run=%b exp %b %b %0d 1",
                     c, hall, step_strobe, step_count, running, eh, es, ec);
         end
      end
   endtask

   task automatic test_cw();
      logic [2:0] eh; logic es; logic signed [15:0] ec; int steps;
      apply_reset(1'b1, 1'b0, 16'd3);
      for (int c = 1; c <= 21; c++) begin
         @(posedge clk); #1;
         steps = c / 3;
         eh = tbl[(6 - steps % 6) % 6]; es = (c % 3 == 0); ec = 16'(0 - steps);
         tests++;
         if (hall !== eh || step_strobe !== es || step_count !== ec) begin
            fails++;
            $display("FAIL cw c=%0d got hall=%b strobe=%b count=%0d exp %b %b %0d",
                     c, hall, step_strobe, step_count, eh, es, ec);
         end
      end
   endtask

   task automatic test_period_change();
      logic [2:0] eh; logic es; logic signed [15:0] ec;
      apply_reset(1'b1, 1'b1, 16'd1);
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         tests++;
         if (hall !== tbl[c % 6] || step_strobe !== 1'b1 || step_count !== 16'(c)) begin
            fails++;
            $display("FAIL period1 c=%0d got hall=%b strobe=%b count=%0d exp %b 1 %0d",
                     c, hall, step_strobe, step_count, tbl[c % 6], c);
         end
      end
      step_period = 16'd100;
      repeat (50) @(posedge clk);
      #1;
      tests++;
      if (hall !== tbl[2] || step_strobe !== 1'b0 || step_count !== 16'sd8) begin
         fails++;
         $display("FAIL period100 got hall=%b strobe=%b count=%0d exp %b 0 8",
                  hall, step_strobe, step_count, tbl[2]);
      end
      step_period = 16'd2;
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         es = (c % 2 == 1); ec = 16'(8 + (c + 1) / 2); eh = tbl[(8 + (c + 1) / 2) % 6];
         tests++;
         if (hall !== eh || step_strobe !== es || step_count !== ec) begin
            fails++;
            $display("FAIL shrink c=%0d got hall=%b strobe=%b count=%0d exp %b %b %0d",
                     c, hall, step_strobe, step_count, eh, es, ec);
         end
      end
   endtask

   task automatic test_force();
      logic [2:0] eh; logic signed [15:0] ec; logic ff, nc;
      apply_reset(1'b1, 1'b1, 16'd4);
      for (int c = 1; c <= 40; c++) begin
         ff = (c >= 7 && c <= 16);
         nc = ff || (c >= 23 && c <= 32);
         force_fault  = ff;
         force_noconn = nc;
         @(posedge clk); #1;
         eh = ff ? 3'b000 : (nc ? 3'b111 : tbl[(c / 4) % 6]);
         ec = 16'(c / 4);
         tests++;
         if (hall !== eh || step_count !== ec) begin
            fails++;
            $display("FAIL force c=%0d got hall=%b count=%0d exp %b %0d", c, hall, step_count, eh, ec);
         end
      end
      force_fault = 1'b0; force_noconn = 1'b0;
   endtask

   task automatic test_wrap_and_reverse();
      apply_reset(1'b1, 1'b1, 16'd1);
      repeat (32766) @(posedge clk);
      #1;
      tests++;
      if (step_count !== 16'sh7FFE || step_strobe !== 1'b1) begin
         fails++;
         $display("FAIL wrap_pre got count=%h strobe=%b exp 7ffe 1", step_count, step_strobe);
      end
      @(posedge clk); #1;
      tests++;
      if (step_count !== 16'sh7FFF) begin
         fails++;
         $display("FAIL wrap_max got count=%h exp 7fff", step_count);
      end
      @(posedge clk); #1;
      tests++;
      if (step_count !== 16'sh8000 || hall !== 3'b110) begin
         fails++;
         $display("FAIL wrap_min got count=%h hall=%b exp 8000 110", step_count, hall);
      end
      step_period = 16'd4;
      repeat (2) @(posedge clk);
      #1;
      direction = 1'b0;
      @(posedge clk); #1;
      tests++;
      if (step_strobe !== 1'b0 || step_count !== 16'sh8000) begin
         fails++;
         $display("FAIL rev_mid got strobe=%b count=%h exp 0 8000", step_strobe, step_count);
      end
      @(posedge clk); #1;
      tests++;
      if (step_strobe !== 1'b1 || step_count !== 16'sh7FFF || hall !== 3'b100) begin
         fails++;
         $display("FAIL rev_step got strobe=%b count=%h hall=%b exp 1 7fff 100",
                  step_strobe, step_count, hall);
      end
   endtask

   task automatic test_enable_and_reset();
      apply_reset(1'b1, 1'b1, 16'd5);
      repeat (7) @(posedge clk);
      #1;
      enable = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge clk); #1;
         tests++;
         if (hall !== tbl[1] || step_strobe !== 1'b0 || step_count !== 16'sd1 || running !== 1'b0) begin
            fails++;
            $display("FAIL hold c=%0d got hall=%b strobe=%b count=%0d run=%b exp %b 0 1 0",
                     c, hall, step_strobe, step_count, running, tbl[1]);
         end
      end
      enable = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (step_strobe !== 1'b0 || step_count !== 16'sd1) begin
         fails++;
         $display("FAIL reen_early got strobe=%b count=%0d exp 0 1", step_strobe, step_count);
      end
      @(posedge clk); #1;
      tests++;
      if (step_strobe !== 1'b1 || step_count !== 16'sd2 || hall !== tbl[2]) begin
         fails++;
         $display("FAIL reen_step got strobe=%b count=%0d hall=%b exp 1 2 %b",
                  step_strobe, step_count, hall, tbl[2]);
      end
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (hall !== 3'b101 || step_count !== 16'sd0 || step_strobe !== 1'b0 || running !== 1'b0) begin
         fails++;
         $display("FAIL async_rst got hall=%b count=%0d strobe=%b run=%b exp 101 0 0 0",
                  hall, step_count, step_strobe, running);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (step_strobe !== 1'b0 || step_count !== 16'sd0 || hall !== 3'b101) begin
         fails++;
         $display("FAIL post_rst_early got strobe=%b count=%0d hall=%b exp 0 0 101",
                  step_strobe, step_count, hall);
      end
      @(posedge clk); #1;
      tests++;
      if (step_strobe !== 1'b1 || step_count !== 16'sd1 || hall !== 3'b100) begin
         fails++;
         $display("FAIL post_rst_step got strobe=%b count=%0d hall=%b exp 1 1 100",
                  step_strobe, step_count, hall);
      end
   endtask

   initial begin
      tbl[0] = 3'b101; tbl[1] = 3'b100; tbl[2] = 3'b110;
      tbl[3] = 3'b010; tbl[4] = 3'b011; tbl[5] = 3'b001;
      test_reset();
      test_ccw();
      test_cw();
      test_period_change();
      test_force();
      test_wrap_and_reverse();
      test_enable_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
